hazard_control_unit: RTL and testbench

//  Back-pressure side of the ID/EX pipeline register: reads what ID/EX currently holds (EX_MemRead, EX rt,
//  EX branch/jr outcome), compares it with the instruction in ID, and drives stall/flush controls back to PC, IF/ID, ID/EX.

---
 rtl/mips_pipe_pkg.sv | 26 ++
 rtl/hazard_bubble_counter.sv | 41 ++++
 rtl/hazard_control_unit.sv | 140 ++++++++++++++
 tb/tb_hazard_control_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// ============================================================================
// mips_pipe_pkg : shared pipeline constants, hazard FSM states, bubble cmds
// Revision 1.0
// ============================================================================
`default_nettype none

package mips_pipe_pkg;

  localparam int                   REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO  = 5'd0;

  typedef enum logic [0:0] {
    HZ_RUN   = 1'b0,
    HZ_STALL = 1'b1
  } hz_state_t;

  typedef enum logic [1:0] {
    BC_HOLD = 2'd0,
    BC_LOAD = 2'd1,
    BC_DEC  = 2'd2,
    BC_CLR  = 2'd3
  } bubble_cmd_t;

endpackage

`default_nettype wire

// File: rtl/hazard_bubble_counter.sv
// ============================================================================
// hazard_bubble_counter : loadable down-counter sequencing load-use bubbles
// Revision 1.0
// ============================================================================
`default_nettype none

module hazard_bubble_counter
  import mips_pipe_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  bubble_cmd_t      i_cmd,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // Decrement saturates at zero so a stray DEC can never wrap into a long stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      case (i_cmd)
        BC_LOAD: r_count <= i_load_val;
        BC_DEC:  r_count <= (r_count == '0) ? '0 : r_count - 1'b1;
        BC_CLR:  r_count <= '0;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/hazard_control_unit.sv
// ============================================================================
// hazard_control_unit : load-use stall / redirect flush control beside ID.
// Optional HAZARD_STATS_EN adds stall/flush event counters.  Revision 1.0
// ============================================================================
`default_nettype none

module hazard_control_unit
  import mips_pipe_pkg::*;
#(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int CNT_W            = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] i_id_rs,
  input  logic [REG_IDX_W-1:0] i_id_rt,
  input  logic                 i_id_uses_rt,
  input  logic                 i_ex_mem_read,
  input  logic [REG_IDX_W-1:0] i_ex_rt,
  input  logic                 i_ex_redirect,
  input  logic                 i_ext_stall,
  output logic                 o_pc_write,
  output logic                 o_if_id_write,
  output logic                 o_if_id_flush,
  output logic                 o_id_ex_flush,
  output logic                 o_stalled,
  output logic [31:0]          o_stall_count,
  output logic [31:0]          o_flush_count
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOAD_USE_BUBBLES - 1);

  hz_state_t        r_state;
  hz_state_t        w_state_nxt;
  bubble_cmd_t      w_cmd;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_zero;
  logic             w_hazard;
  logic             w_last;
  logic             w_pc_write;
  logic             w_if_id_write;
  logic             w_if_id_flush;
  logic             w_id_ex_flush;
  logic             w_stalled;

  assign w_hazard = i_ex_mem_read & (i_ex_rt != REG_ZERO) &
                    ((i_ex_rt == i_id_rs) | (i_id_uses_rt & (i_ex_rt == i_id_rt)));

  // Treat an already-empty counter as the last bubble so STALL can never stick.
  assign w_last = (w_cnt == CNT_W'(1)) | w_cnt_zero;

  hazard_bubble_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_counter (
    .clk        (clk),
    .reset      (reset),
    .i_cmd      (w_cmd),
    .i_load_val (LOAD_VAL),
    .o_count    (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= HZ_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cmd         = BC_HOLD;
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_stalled     = 1'b0;
    if (i_ex_redirect) begin
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
      w_state_nxt   = HZ_RUN;
      w_cmd         = BC_CLR;
    end else if (i_ext_stall) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_stalled     = 1'b1;
    end else if (r_state == HZ_STALL) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_id_ex_flush = 1'b1;
      w_stalled     = 1'b1;
      w_cmd         = BC_DEC;
      if (w_last) begin
        w_state_nxt = HZ_RUN;
      end
    end else if (w_hazard) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_id_ex_flush = 1'b1;
      w_stalled     = 1'b1;
      if (LOAD_USE_BUBBLES > 1) begin
        w_state_nxt = HZ_STALL;
        w_cmd       = BC_LOAD;
      end
    end
  end

  // While reset is asserted the front end runs freely regardless of inputs.
  assign o_pc_write    = ~reset | w_pc_write;
  assign o_if_id_write = ~reset | w_if_id_write;
  assign o_if_id_flush = reset & w_if_id_flush;
  assign o_id_ex_flush = reset & w_id_ex_flush;
  assign o_stalled     = reset & w_stalled;

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else if (i_ex_redirect) begin
      r_flush_count <= r_flush_count + 32'd1;
    end else if (w_id_ex_flush) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign o_stall_count = r_stall_count;
  assign o_flush_count = r_flush_count;
`else
  assign o_stall_count = 32'b0;
  assign o_flush_count = 32'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
// ============================================================================
// tb_hazard_control_unit : vector table + multi-cycle sequences for hazard unit
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_hazard_control_unit;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, ex_redirect, ext_stall;

  logic        a_pw, a_ifw, a_iff, a_ief, a_st;
  logic [31:0] a_sc, a_fc;
  logic        b_pw, b_ifw, b_iff, b_ief, b_st;
  logic [31:0] b_sc, b_fc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.LOAD_USE_BUBBLES(1), .CNT_W(3)) u_dut1 (
    .clk(clk), .reset(reset), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_ex_redirect(ex_redirect),
    .i_ext_stall(ext_stall), .o_pc_write(a_pw), .o_if_id_write(a_ifw),
    .o_if_id_flush(a_iff), .o_id_ex_flush(a_ief), .o_stalled(a_st),
    .o_stall_count(a_sc), .o_flush_count(a_fc)
  );

  hazard_control_unit #(.LOAD_USE_BUBBLES(3), .CNT_W(3)) u_dut3 (
    .clk(clk), .reset(reset), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_ex_redirect(ex_redirect),
    .i_ext_stall(ext_stall), .o_pc_write(b_pw), .o_if_id_write(b_ifw),
    .o_if_id_flush(b_iff), .o_id_ex_flush(b_ief), .o_stalled(b_st),
    .o_stall_count(b_sc), .o_flush_count(b_fc)
  );

  typedef struct {
    logic       mr;
    logic [4:0] ert;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic       redir;
    logic       xst;
    logic [4:0] exp;  // {pc_write, if_id_write, if_id_flush, id_ex_flush, stalled}
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic uses, input logic redir, input logic xst);
    ex_mem_read = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
    id_uses_rt = uses; ex_redirect = redir; ext_stall = xst;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    cyc();
    reset = 1'b1;
    #1;
  endtask

  logic [5:0] exp_st, exp_ief;
  int         nst;

  initial begin
    tbl[0]  = '{1'b1, 5'd2,  5'd2,  5'd5, 1'b1, 1'b0, 1'b0, 5'b00011};
    tbl[1]  = '{1'b1, 5'd0,  5'd0,  5'd0, 1'b1, 1'b0, 1'b0, 5'b11000};
    tbl[2]  = '{1'b1, 5'd7,  5'd3,  5'd7, 1'b1, 1'b0, 1'b0, 5'b00011};
    tbl[3]  = '{1'b1, 5'd7,  5'd3,  5'd7, 1'b0, 1'b0, 1'b0, 5'b11000};
    tbl[4]  = '{1'b0, 5'd7,  5'd7,  5'd7, 1'b1, 1'b0, 1'b0, 5'b11000};
    tbl[5]  = '{1'b1, 5'd4,  5'd4,  5'd0, 1'b0, 1'b1, 1'b0, 5'b11110};
    tbl[6]  = '{1'b1, 5'd4,  5'd4,  5'd0, 1'b0, 1'b0, 1'b1, 5'b00001};
    tbl[7]  = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b1, 5'b11110};
    tbl[8]  = '{1'b1, 5'd9,  5'd1,  5'd2, 1'b1, 1'b0, 1'b0, 5'b11000};
    tbl[9]  = '{1'b1, 5'd31, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00011};
    tbl[10] = '{1'b1, 5'd0,  5'd3,  5'd0, 1'b1, 1'b0, 1'b0, 5'b11000};

    // Reset state, with a live hazard on the inputs that must be ignored.
    reset = 1'b0;
    drive(1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_outputs", {b_pw, b_ifw, b_iff, b_ief, b_st}, 5'b11000);
    chk("rst_stall_count", b_sc, 32'd0);
    chk("rst_flush_count", b_fc, 32'd0);
    cyc();
    idle();
    reset = 1'b1;
    #1;

    // Single-bubble unit: pure combinational decision every cycle.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].mr, tbl[i].ert, tbl[i].rs, tbl[i].rt, tbl[i].uses, tbl[i].redir, tbl[i].xst);
      #2;
      chk($sformatf("vec%0d", i), {a_pw, a_ifw, a_iff, a_ief, a_st}, tbl[i].exp);
      cyc();
    end

    // Three-bubble load-use on rt.
    do_reset();
    exp_st = 6'b000111;
    nst = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(1'b1, 5'd4, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0);
      else idle();
      #2;
      chk($sformatf("lu3_stalled_c%0d", i), b_st, exp_st[i]);
      if (b_st) nst++;
      cyc();
    end
    chk("lu3_total", nst, 3);
    chk("lu3_stall_count", b_sc, STATS ? 32'd3 : 32'd0);
    chk("lu3_flush_count", b_fc, 32'd0);

    // Hazard and redirect together: redirect wins, no bubble sequence starts.
    do_reset();
    drive(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0);
    #2;
    chk("redir_hz_outputs", {b_pw, b_ifw, b_iff, b_ief, b_st}, 5'b11110);
    cyc();
    idle();
    #2;
    chk("redir_hz_after", {b_pw, b_st}, 2'b10);
    chk("redir_stall_count", b_sc, 32'd0);
    chk("redir_flush_count", b_fc, STATS ? 32'd1 : 32'd0);
    cyc();

    // ext_stall freezes the bubble counter mid-STALL.
    do_reset();
    exp_st  = 6'b011111;
    exp_ief = 6'b011001;
    nst = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
      else if (i == 1 || i == 2) drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      else idle();
      #2;
      chk($sformatf("xst_c%0d", i), {b_st, b_ief}, {exp_st[i], exp_ief[i]});
      if (b_st) nst++;
      cyc();
    end
    chk("xst_total", nst, 5);
    chk("xst_stall_count", b_sc, STATS ? 32'd3 : 32'd0);

    // Asynchronous reset in the middle of STALL.
    do_reset();
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    idle();
    #2;
    chk("arst_pre_stalled", b_st, 1'b1);
    reset = 1'b0;
    #1;
    chk("arst_immediate", {b_pw, b_st}, 2'b10);
    cyc();
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("arst_after_c%0d", i), {b_pw, b_st}, 2'b10);
      cyc();
    end
    chk("arst_stall_count", b_sc, 32'd0);
    chk("arst_flush_count", b_fc, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
